player_move_ctrl: RTL and testbench
===================================

// Module: player_move_ctrl
// PURPOSE
//  Maze player controller; feeds the VGA maze renderer the player cell position.
//  Samples direction switches once per frame and checks the target cell against
//  the maze wall memory through a 1-cycle-latency read port.
//  Moves the player one cell per step period and flags arrival at the goal cell.
// PARAMETERS
//  MAZE_W           20  maze width in cells (640/32)
//  MAZE_H           15  maze height in cells (480/32)
//  START_X / START_Y 1/1  player cell after reset
//  GOAL_X / GOAL_Y  18/13 goal cell
//  FRAMES_PER_STEP  8   frame_tick pulses per movement attempt (>=1)
// PORTS
//  clk            in   1  system clock (50 MHz)
//  rst            in   1  synchronous, active-high reset
//  frame_tick     in   1  one-cycle pulse per frame (start of vblank)
//  dir            in   4  SW[3:0]: [0]=right [1]=left [2]=down [3]=up
//  maze_rd        out  1  wall-memory read strobe, one cycle
//  maze_addr      out  9  target cell index = y*MAZE_W + x
//  maze_wall      in   1  1 = wall; valid the cycle after maze_rd
//  player_x       out  5  current cell column
//  player_y       out  4  current cell row
//  goal_reached   out  1  sticky: player has reached (GOAL_X,GOAL_Y)
// BEHAVIOUR
//  Reset: player_x=START_X, player_y=START_Y, maze_rd=0, maze_addr=0,
//   goal_reached=0, step counter=0, FSM=IDLE. Reset mid-operation aborts any read.
//  Step counter: counts frame_ticks while dir is valid (exactly one bit set);
//   cleared to 0 when dir is invalid. An attempt fires on the frame_tick with count
//   == FRAMES_PER_STEP-1, and the counter returns to 0.
//  dir invalid (zero or >1 bit set): no attempt, no maze_rd.
//  FSM: IDLE -> (attempt, target in range) CHECK -> WAIT_RD -> COMMIT -> IDLE.
//   CHECK: maze_rd=1, maze_addr=target index (target latched from dir at attempt).
//   WAIT_RD: sample maze_wall. COMMIT: if !wall, update player_x/y to target.
//   Position changes 3 cycles after the firing frame_tick; maze_rd rises 1 cycle after.
//  frame_tick while FSM != IDLE: counted but never fires an attempt; counter holds at
//   FRAMES_PER_STEP-1 until IDLE.
//  Out of range (x=0 left, x=MAZE_W-1 right, y=0 up, y=MAZE_H-1 down): blocked,
//   no maze_rd, FSM stays IDLE.
//  Goal: goal_reached set in the cycle after COMMIT lands on goal; once set, no
//   further attempts until rst. Starting on goal does not set it.
//  Arithmetic: maze_addr computed at 9 bits, no truncation for MAZE_W*MAZE_H<=512.
// CONFIGURATION
//  PLAYER_WRAP_EN defined: out-of-range targets wrap to the opposite edge
//   (x=0 left -> MAZE_W-1, etc.) and are wall-checked normally.
//  Not defined: out-of-range targets are blocked as above.
// STRUCTURE
//  maze_pkg: MAZE_W, MAZE_H, coordinate widths, DIR_* bit indices, FSM state enum,
//   cell_index() function (y*MAZE_W+x), shared with renderer and wall ROM.
//  Sub-module step_timer: frame_tick counter with valid-clear, emits step pulse.
// TESTING
//  1 rst pulse -> player=(1,1), goal_reached=0, maze_rd=0 next cycle.
//  2 dir=0001, wall=0, 8 frame_ticks -> maze_rd 1 cycle after 8th tick with addr 22;
//    player_x=2 3 cycles after tick.
//  3 dir=0100, wall=1 -> maze_rd pulses, addr=41, player unchanged.
//  4 dir=0011 or 0000 for 20 frame_ticks -> maze_rd never asserts, counter stays 0.
//  5 player at x=0, dir=0010 -> no maze_rd; with PLAYER_WRAP_EN -> addr y*20+19,
//    player_x=19 if open.
//  6 step onto (18,13) -> goal_reached=1 and sticky; rst asserted during WAIT_RD ->
//    player=(1,1), maze_rd=0, goal_reached=0.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: maze geometry, coordinate widths, direction switch bit indices,
// the player-move FSM state type and the cell index helper. Shared by the
// player controller, the renderer and the wall ROM.
package maze_pkg;

  localparam int MAZE_W = 20;  // cells across (640/32)
  localparam int MAZE_H = 15;  // cells down (480/32)
  localparam int X_W    = 5;   // column width
  localparam int Y_W    = 4;   // row width
  localparam int ADDR_W = 9;   // cell index width, MAZE_W*MAZE_H <= 512

  // Bit positions inside the 4-bit direction switch bus
  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_COMMIT  = 2'd3
  } move_state_t;

  // Row-major cell index y*MAZE_W + x, evaluated at full address width
  function automatic logic [ADDR_W-1:0] cell_index(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(MAZE_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: counts frame ticks while the direction input is valid and
// emits a one-cycle step pulse every FRAMES_PER_STEP ticks.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   frame_tick   one-cycle pulse per frame
//   dir_valid    exactly one direction bit set; low clears the count
//   ready        consumer can accept a step; while low the count parks on
//                its last value so the step fires once the consumer frees up
//   step         combinational pulse, coincident with the firing frame_tick
module step_timer #(
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic dir_valid,
  input  logic ready,
  output logic step
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             at_last_s;

  assign at_last_s = (cnt_r == LAST);
  assign step      = frame_tick & dir_valid & ready & at_last_s;

  // Frame tick counter with clear on invalid direction and hold while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!dir_valid) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (frame_tick) begin
      if (at_last_s) begin
        if (ready) begin
          cnt_r <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: maze player controller. Samples the direction switches
// per frame, wall-checks the target cell through a 1-cycle-latency read port
// and moves the player one cell per step period.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_tick    one-cycle pulse per frame
//   dir[3:0]      [0]=right [1]=left [2]=down [3]=up
//   maze_rd       wall-memory read strobe (one cycle)
//   maze_addr     target cell index y*MAZE_W+x
//   maze_wall     1 = wall, valid the cycle after maze_rd
//   player_x/y    current player cell
//   goal_reached  sticky goal flag, cleared only by rst
// Build option: define PLAYER_WRAP_EN to wrap moves off an edge to the
// opposite edge instead of blocking them.
module player_move_ctrl
  import maze_pkg::*;
#(
  parameter int START_X         = 1,
  parameter int START_Y         = 1,
  parameter int GOAL_X          = 18,
  parameter int GOAL_Y          = 13,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic [3:0]        dir,
  output logic              maze_rd,
  output logic [ADDR_W-1:0] maze_addr,
  input  logic              maze_wall,
  output logic [X_W-1:0]    player_x,
  output logic [Y_W-1:0]    player_y,
  output logic              goal_reached
);

  move_state_t    state_r;
  logic [X_W-1:0] tgt_x_r;
  logic [Y_W-1:0] tgt_y_r;
  logic           moved_r;

  logic           dir_valid_s;
  logic           ready_s;
  logic           step_s;
  logic [X_W-1:0] next_x_s;
  logic [Y_W-1:0] next_y_s;
  logic           in_range_s;

  assign dir_valid_s = $onehot(dir);
  assign ready_s     = (state_r == ST_IDLE) & ~goal_reached;

  step_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_step_timer (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .dir_valid  (dir_valid_s),
    .ready      (ready_s),
    .step       (step_s)
  );

  // Target cell and edge handling for the requested direction
  always_comb begin
    next_x_s   = player_x;
    next_y_s   = player_y;
    in_range_s = 1'b0;
    if (dir[DIR_RIGHT]) begin
      if (player_x == X_W'(MAZE_W - 1)) begin
`ifdef PLAYER_WRAP_EN
        next_x_s   = {X_W{1'b0}};
        in_range_s = 1'b1;
`else
        in_range_s = 1'b0;
`endif
      end else begin
        next_x_s   = player_x + X_W'(1);
        in_range_s = 1'b1;
      end
    end else if (dir[DIR_LEFT]) begin
      if (player_x == {X_W{1'b0}}) begin
`ifdef PLAYER_WRAP_EN
        next_x_s   = X_W'(MAZE_W - 1);
        in_range_s = 1'b1;
`else
        in_range_s = 1'b0;
`endif
      end else begin
        next_x_s   = player_x - X_W'(1);
        in_range_s = 1'b1;
      end
    end else if (dir[DIR_DOWN]) begin
      if (player_y == Y_W'(MAZE_H - 1)) begin
`ifdef PLAYER_WRAP_EN
        next_y_s   = {Y_W{1'b0}};
        in_range_s = 1'b1;
`else
        in_range_s = 1'b0;
`endif
      end else begin
        next_y_s   = player_y + Y_W'(1);
        in_range_s = 1'b1;
      end
    end else if (dir[DIR_UP]) begin
      if (player_y == {Y_W{1'b0}}) begin
`ifdef PLAYER_WRAP_EN
        next_y_s   = Y_W'(MAZE_H - 1);
        in_range_s = 1'b1;
`else
        in_range_s = 1'b0;
`endif
      end else begin
        next_y_s   = player_y - Y_W'(1);
        in_range_s = 1'b1;
      end
    end else begin
      in_range_s = 1'b0;
    end
  end

  // Move FSM: read the target cell, wait for the wall bit, then commit.
  // The position register loads at the end of WAIT_RD (the wall bit is valid
  // then), so COMMIT already presents the new cell and evaluates the goal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      player_x     <= X_W'(START_X);
      player_y     <= Y_W'(START_Y);
      tgt_x_r      <= {X_W{1'b0}};
      tgt_y_r      <= {Y_W{1'b0}};
      moved_r      <= 1'b0;
      maze_rd      <= 1'b0;
      maze_addr    <= {ADDR_W{1'b0}};
      goal_reached <= 1'b0;
    end else begin
      maze_rd <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Out-of-range attempts consume the step but never touch memory
          if (step_s && in_range_s) begin
            tgt_x_r   <= next_x_s;
            tgt_y_r   <= next_y_s;
            maze_rd   <= 1'b1;
            maze_addr <= cell_index(next_x_s, next_y_s);
            state_r   <= ST_CHECK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          state_r <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          moved_r <= ~maze_wall;
          if (!maze_wall) begin
            player_x <= tgt_x_r;
            player_y <= tgt_y_r;
          end else begin
            player_x <= player_x;
            player_y <= player_y;
          end
          state_r <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Only an actual move onto the goal counts, not sitting on it
          if (moved_r && (player_x == X_W'(GOAL_X)) && (player_y == Y_W'(GOAL_Y))) begin
            goal_reached <= 1'b1;
          end else begin
            goal_reached <= goal_reached;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: reset, wall hit, open move, invalid
// direction clearing, edge handling, goal arrival and reset during a read.
module tb_player_move_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic [3:0] dir;
  logic       maze_rd;
  logic [8:0] maze_addr;
  logic       maze_wall;
  logic [4:0] player_x;
  logic [3:0] player_y;
  logic       goal_reached;

  int checks = 0;
  int errors = 0;
  logic rd_seen;

  player_move_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .dir          (dir),
    .maze_rd      (maze_rd),
    .maze_addr    (maze_addr),
    .maze_wall    (maze_wall),
    .player_x     (player_x),
    .player_y     (player_y),
    .goal_reached (goal_reached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame tick; returns #1 after the edge that sampled it
  task automatic pulse_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // n ticks with a gap cycle each, recording any maze_rd
  task automatic ticks_watch(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_tick();
      rd_seen = rd_seen | maze_rd;
      cyc();
      rd_seen = rd_seen | maze_rd;
    end
  endtask

  // Full step period: 7 quiet ticks, then the firing tick and its outcome
  task automatic step_move(input string tag, input logic [3:0] d, input logic w,
                           input logic exp_rd, input logic [8:0] exp_addr,
                           input logic [4:0] exp_x, input logic [3:0] exp_y);
    dir       = d;
    maze_wall = w;
    rd_seen   = 1'b0;
    ticks_watch(7);
    check({tag, "_early_rd"}, 32'(rd_seen), 32'd0);
    pulse_tick();
    check({tag, "_rd"}, 32'(maze_rd), 32'(exp_rd));
    if (exp_rd) check({tag, "_addr"}, 32'(maze_addr), 32'(exp_addr));
    cyc();
    check({tag, "_rd_off"}, 32'(maze_rd), 32'd0);
    cyc();
    check({tag, "_x"}, 32'(player_x), 32'(exp_x));
    check({tag, "_y"}, 32'(player_y), 32'(exp_y));
    cyc();
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    dir        = 4'b0000;
    maze_wall  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_x", 32'(player_x), 32'd1);
    check("rst_y", 32'(player_y), 32'd1);
    check("rst_rd", 32'(maze_rd), 32'd0);
    check("rst_addr", 32'(maze_addr), 32'd0);
    check("rst_goal", 32'(goal_reached), 32'd0);

    // Down into a wall: read of cell 41, player stays put
    step_move("wall_down", 4'b0100, 1'b1, 1'b1, 9'd41, 5'd1, 4'd1);
    // Right into open cell 22; x must still be old one cycle earlier
    dir       = 4'b0001;
    maze_wall = 1'b0;
    rd_seen   = 1'b0;
    ticks_watch(7);
    check("right_early_rd", 32'(rd_seen), 32'd0);
    pulse_tick();
    check("right_rd", 32'(maze_rd), 32'd1);
    check("right_addr", 32'(maze_addr), 32'd22);
    cyc();
    check("right_x_t2", 32'(player_x), 32'd1);
    cyc();
    check("right_x_t3", 32'(player_x), 32'd2);
    check("right_y_t3", 32'(player_y), 32'd1);
    cyc();

    // Partial count, then invalid directions must clear it and never read
    rd_seen = 1'b0;
    dir = 4'b0001;
    ticks_watch(5);
    dir = 4'b0011;
    ticks_watch(10);
    dir = 4'b0000;
    ticks_watch(10);
    check("invalid_no_rd", 32'(rd_seen), 32'd0);
    check("invalid_x", 32'(player_x), 32'd2);

    // Full 8 ticks needed again after the clear
    step_move("left1", 4'b0010, 1'b0, 1'b1, 9'd21, 5'd1, 4'd1);
    step_move("left0", 4'b0010, 1'b0, 1'b1, 9'd20, 5'd0, 4'd1);
`ifdef PLAYER_WRAP_EN
    step_move("wrap_left", 4'b0010, 1'b0, 1'b1, 9'd39, 5'd19, 4'd1);
    step_move("wrap_right", 4'b0001, 1'b0, 1'b1, 9'd20, 5'd0, 4'd1);
`else
    step_move("edge_left", 4'b0010, 1'b0, 1'b0, 9'd0, 5'd0, 4'd1);
`endif

    // Walk to the goal: along row 1 to x=18, then down column 18 to y=13
    for (int i = 1; i <= 18; i++) begin
      step_move("path_r", 4'b0001, 1'b0, 1'b1, 9'(20 + i), 5'(i), 4'd1);
    end
    for (int j = 2; j <= 13; j++) begin
      if (j == 13) check("goal_before", 32'(goal_reached), 32'd0);
      step_move("path_d", 4'b0100, 1'b0, 1'b1, 9'(j * 20 + 18), 5'd18, 4'(j));
    end
    check("goal_set", 32'(goal_reached), 32'd1);
    // No attempts after the goal, flag stays set
    step_move("goal_hold", 4'b0100, 1'b0, 1'b0, 9'd0, 5'd18, 4'd13);
    check("goal_sticky", 32'(goal_reached), 32'd1);

    // Reset clears the goal and restores the start cell
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_goal", 32'(goal_reached), 32'd0);
    check("rst2_x", 32'(player_x), 32'd1);
    check("rst2_y", 32'(player_y), 32'd1);

    // Reset while waiting on the wall bit aborts the move
    dir       = 4'b0001;
    maze_wall = 1'b0;
    rd_seen   = 1'b0;
    ticks_watch(7);
    pulse_tick();
    check("abort_rd", 32'(maze_rd), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dir = 4'b0000;
    check("abort_rd_off", 32'(maze_rd), 32'd0);
    check("abort_x", 32'(player_x), 32'd1);
    check("abort_y", 32'(player_y), 32'd1);
    check("abort_goal", 32'(goal_reached), 32'd0);
    cyc();
    cyc();
    check("abort_x_late", 32'(player_x), 32'd1);
    check("abort_addr", 32'(maze_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
